// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: widths, control-word layout, ALU opcodes
// and the DSEL/PCSEL encodings.
package legv8_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [REG_W-1:0] XZR = 5'd31;

  // FS[4:2]; FS[1:0] are the A/B inversion bits
  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_OR    = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_XOR   = 3'b011,
    ALU_LSL   = 3'b100,
    ALU_LSR   = 3'b101,
    ALU_ZERO0 = 3'b110,
    ALU_ZERO1 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    DSEL_ALU     = 2'b00,
    DSEL_MEM     = 2'b01,
    DSEL_PC4     = 2'b10,
    DSEL_MEM_ALT = 2'b11
  } dsel_e;

  typedef enum logic [1:0] {
    PCSEL_HOLD   = 2'b00,
    PCSEL_INC    = 2'b01,
    PCSEL_REG    = 2'b10,
    PCSEL_BRANCH = 2'b11
  } pcsel_e;

  // Field order fixes the bit positions, MSB (bit 39) first
  typedef struct packed {
    logic [5:0]       rsvd_hi;
    logic             pc_en;
    dsel_e            dsel;
    pcsel_e           pcsel;
    logic             asel;
    logic             bsel;
    logic             ir_ld;
    logic             rsvd_25;
    logic [4:0]       fs;
    logic             c0;
    logic             rsvd_18;
    logic             sl;
    logic             mem_wr;
    logic             reg_wr;
    logic [REG_W-1:0] da;
    logic [REG_W-1:0] sa;
    logic [REG_W-1:0] sb;
  } ctrl_word_t;

endpackage

// File: rtl/legv8_alu.sv
// LEGv8 64-bit function unit: optional operand inversion, logic/add/shift ops,
// flags {V,C,N,Z}; C and V are only meaningful for ADD.
module legv8_alu
  import legv8_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [4:0]        i_fs,
  input  logic              i_c0,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags
);

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_ovf;
  logic              w_is_add;
  alu_op_e           w_op;

  assign w_a  = i_fs[1] ? ~i_a : i_a;
  assign w_b  = i_fs[0] ? ~i_b : i_b;
  assign w_op = alu_op_e'(i_fs[4:2]);

  assign {w_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, i_c0};

  always_comb begin
    o_result = '0;
    unique case (w_op)
      ALU_AND:   o_result = w_a & w_b;
      ALU_OR:    o_result = w_a | w_b;
      ALU_ADD:   o_result = w_sum;
      ALU_XOR:   o_result = w_a ^ w_b;
      ALU_LSL:   o_result = w_a << w_b[5:0];
      ALU_LSR:   o_result = w_a >> w_b[5:0];
      ALU_ZERO0: o_result = '0;
      ALU_ZERO1: o_result = '0;
    endcase
  end

  assign w_is_add = (w_op == ALU_ADD);
  assign w_ovf    = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);

  assign o_flags = {w_is_add & w_ovf, w_is_add & w_cout, o_result[DATA_W-1], o_result == '0};

endmodule

// File: rtl/legv8_datapath_ts.sv
// LEGv8 datapath steered by an external 40-bit control word: register file, PC,
// IR, status register, tri-state data bus. LEGV8_DEBUG_REGS_EN exposes X0..X7 on r0..r7.
module legv8_datapath_ts
  import legv8_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [39:0]       ControlWord,
  inout  wire  [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] constant,
  output logic [4:0]        status,
  output logic [31:0]       IR_out,
  output logic [3:0]        current_status,
  output logic [15:0]       r0,
  output logic [15:0]       r1,
  output logic [15:0]       r2,
  output logic [15:0]       r3,
  output logic [15:0]       r4,
  output logic [15:0]       r5,
  output logic [15:0]       r6,
  output logic [15:0]       r7
);

  ctrl_word_t        w_cw;
  logic              w_unused_cw;
  logic [DATA_W-1:0] r_regs [0:31];
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [3:0]        r_cstat;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b_reg;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [3:0]        w_alu_flags;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_pc_branch;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_cw        = ControlWord;
  assign w_unused_cw = ^{w_cw.rsvd_hi, w_cw.rsvd_25, w_cw.rsvd_18, w_cw.mem_wr};

  assign w_a     = (w_cw.sa == XZR) ? '0 : r_regs[w_cw.sa];
  assign w_b_reg = (w_cw.sb == XZR) ? '0 : r_regs[w_cw.sb];
  assign w_b     = w_cw.bsel ? constant : w_b_reg;

  legv8_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_fs     (w_cw.fs),
    .i_c0     (w_cw.c0),
    .o_result (w_alu_res),
    .o_flags  (w_alu_flags)
  );

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_branch = r_pc + {constant[ADDR_W-3:0], 2'b00};

  always_comb begin
    w_wdata = w_alu_res;
    unique case (w_cw.dsel)
      DSEL_ALU:     w_wdata = w_alu_res;
      DSEL_MEM:     w_wdata = data;
      DSEL_PC4:     w_wdata = {32'b0, w_pc_plus4};
      DSEL_MEM_ALT: w_wdata = data;
    endcase
  end

  always_comb begin
    w_pc_next = r_pc;
    unique case (w_cw.pcsel)
      PCSEL_HOLD:   w_pc_next = r_pc;
      PCSEL_INC:    w_pc_next = w_pc_plus4;
      PCSEL_REG:    w_pc_next = w_a[ADDR_W-1:0];
      PCSEL_BRANCH: w_pc_next = w_pc_branch;
    endcase
  end

  assign status         = {w_b_reg == '0, w_alu_flags};
  assign address        = w_cw.asel ? r_pc : w_alu_res[ADDR_W-1:0];
  assign IR_out         = r_ir;
  assign current_status = r_cstat;

  // Bus released during reset so memory never sees a stale register value
  assign data = (!reset && (w_cw.dsel == DSEL_MEM)) ? w_b_reg : 'z;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= '0;
      r_ir    <= '0;
      r_cstat <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        r_regs[i[4:0]] <= '0;
      end
    end else begin
      if (w_cw.reg_wr && (w_cw.da != XZR)) r_regs[w_cw.da] <= w_wdata;
      if (w_cw.pc_en) r_pc <= w_pc_next;
      if (w_cw.ir_ld) r_ir <= data[31:0];
      if (w_cw.sl) r_cstat <= w_alu_flags;
    end
  end

`ifdef LEGV8_DEBUG_REGS_EN
  assign r0 = r_regs[0][15:0];
  assign r1 = r_regs[1][15:0];
  assign r2 = r_regs[2][15:0];
  assign r3 = r_regs[3][15:0];
  assign r4 = r_regs[4][15:0];
  assign r5 = r_regs[5][15:0];
  assign r6 = r_regs[6][15:0];
  assign r7 = r_regs[7][15:0];
`else
  assign r0 = '0;
  assign r1 = '0;
  assign r2 = '0;
  assign r3 = '0;
  assign r4 = '0;
  assign r5 = '0;
  assign r6 = '0;
  assign r7 = '0;
`endif

endmodule

// File: tb/tb_legv8_datapath_ts.sv
// Scoreboard bench for legv8_datapath_ts: expectations queued with each control
// word and compared just after it is applied; registers read back over the data bus.
module tb_legv8_datapath_ts;

  typedef struct packed {
    logic [5:0] rsv_hi;
    logic       pc_en;
    logic [1:0] dsel;
    logic [1:0] pcsel;
    logic       asel;
    logic       bsel;
    logic       ir_ld;
    logic       rsv25;
    logic [4:0] fs;
    logic       c0;
    logic       rsv18;
    logic       sl;
    logic       mem_wr;
    logic       reg_wr;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
  } tb_cw_t;

  typedef enum int {K_ADDR, K_DATA, K_STATUS, K_IR, K_CSTAT, K_DBG} kind_e;

  typedef struct {
    string       tag;
    kind_e       kind;
    int          idx;
    logic [63:0] exp;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [39:0] ControlWord = '0;
  logic [63:0] constant = '0;
  wire  [63:0] data;
  logic [31:0] address;
  logic [4:0]  status;
  logic [31:0] IR_out;
  logic [3:0]  current_status;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] dbg [8];

  logic        tb_drv_en = 1'b0;
  logic [63:0] tb_data = '0;
  assign data = tb_drv_en ? tb_data : 'z;

  assign dbg[0] = r0; assign dbg[1] = r1; assign dbg[2] = r2; assign dbg[3] = r3;
  assign dbg[4] = r4; assign dbg[5] = r5; assign dbg[6] = r6; assign dbg[7] = r7;

  int  n_checks = 0;
  int  n_pass   = 0;
  sb_t sbq[$];

  always #5 clock = ~clock;

  legv8_datapath_ts u_dut (
    .clock          (clock),
    .reset          (reset),
    .ControlWord    (ControlWord),
    .data           (data),
    .address        (address),
    .constant       (constant),
    .status         (status),
    .IR_out         (IR_out),
    .current_status (current_status),
    .r0             (r0),
    .r1             (r1),
    .r2             (r2),
    .r3             (r3),
    .r4             (r4),
    .r5             (r5),
    .r6             (r6),
    .r7             (r7)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] observe(input kind_e k, input int idx);
    case (k)
      K_ADDR:   return {32'b0, address};
      K_DATA:   return data;
      K_STATUS: return {59'b0, status};
      K_IR:     return {32'b0, IR_out};
      K_CSTAT:  return {60'b0, current_status};
      default:  return {48'b0, dbg[idx]};
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_e k, input int idx, input logic [63:0] exp);
    sb_t e;
    e.tag = tag; e.kind = k; e.idx = idx; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic step(input tb_cw_t c, input logic [63:0] k, input logic drv, input logic [63:0] dv);
    @(negedge clock);
    ControlWord = c;
    constant    = k;
    tb_drv_en   = drv;
    tb_data     = dv;
    #2;
    while (sbq.size() > 0) begin
      sb_t e;
      e = sbq.pop_front();
      check(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  function automatic tb_cw_t mk(input logic [4:0] fs, input logic c0, input logic bsel,
                                input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
                                input logic wr, input logic sl);
    tb_cw_t c;
    c = '0;
    c.fs = fs; c.c0 = c0; c.bsel = bsel; c.sa = sa; c.sb = sb; c.da = da;
    c.reg_wr = wr; c.sl = sl;
    return c;
  endfunction

  task automatic read_reg(input int n, input logic [63:0] exp);
    tb_cw_t c;
    c = '0;
    c.dsel = 2'b01;
    c.sb = 5'(n);
    expect_val($sformatf("x%0d_bus", n), K_DATA, 0, exp);
    if (n < 8) begin
`ifdef LEGV8_DEBUG_REGS_EN
      expect_val($sformatf("r%0d_dbg", n), K_DBG, n, {48'b0, exp[15:0]});
`else
      expect_val($sformatf("r%0d_dbg", n), K_DBG, n, 64'd0);
`endif
    end
    step(c, 64'd0, 1'b0, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tb_cw_t      c;
    logic [63:0] k1, k2, x;
    logic [1:0]  pcsel_seq [4];
    logic [31:0] pc_seq [4];

    reset = 1'b1;
    step('0, 64'd0, 1'b0, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    c = '0; c.asel = 1'b1;
    expect_val("rst_pc", K_ADDR, 0, 64'd0);
    expect_val("rst_ir", K_IR, 0, 64'd0);
    expect_val("rst_cstat", K_CSTAT, 0, 64'd0);
    step(c, 64'd0, 1'b0, 64'd0);
    read_reg(0, 64'd0);

    // X0 = 0 | 24
    expect_val("or_addr", K_ADDR, 0, 64'd24);
    expect_val("or_status", K_STATUS, 0, 64'b10000);
    step(mk(5'b00100, 1'b0, 1'b1, 5'd31, 5'd0, 5'd0, 1'b1, 1'b0), 64'd24, 1'b0, 64'd0);
    read_reg(0, 64'd24);

    // X1 = 0 - X0
    expect_val("sub_status", K_STATUS, 0, 64'b00010);
    expect_val("sub_addr", K_ADDR, 0, 64'hFFFF_FFE8);
    step(mk(5'b01001, 1'b1, 1'b0, 5'd31, 5'd0, 5'd1, 1'b1, 1'b1), 64'd0, 1'b0, 64'd0);
    expect_val("sub_cstat", K_CSTAT, 0, 64'b0010);
    read_reg(1, 64'hFFFF_FFFF_FFFF_FFE8);

    expect_val("lsr60_addr", K_ADDR, 0, 64'hF);
    step(mk(5'b10100, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0), 64'd60, 1'b0, 64'd0);

    c = mk(5'b01000, 1'b0, 1'b1, 5'd31, 5'd1, 5'd0, 1'b0, 1'b0);
    c.dsel = 2'b01;
    expect_val("st_addr", K_ADDR, 0, 64'd24);
    expect_val("st_data", K_DATA, 0, 64'hFFFF_FFFF_FFFF_FFE8);
    step(c, 64'd24, 1'b0, 64'd0);

    expect_val("and_addr", K_ADDR, 0, 64'd8);
    step(mk(5'b00000, 1'b0, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b0), 64'd0, 1'b0, 64'd0);
    read_reg(1, 64'd8);

    expect_val("lsl4_addr", K_ADDR, 0, 64'd384);
    step(mk(5'b10000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0), 64'd4, 1'b0, 64'd0);
    expect_val("lsl63_addr", K_ADDR, 0, 64'd0);
    expect_val("lsl63_status", K_STATUS, 0, 64'b00001);
    step(mk(5'b10000, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0), 64'd63, 1'b0, 64'd0);

    c = mk(5'b00000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    c.dsel = 2'b11;
    step(c, 64'd0, 1'b1, 64'h1234);
    read_reg(2, 64'h1234);

    step(mk(5'b00100, 1'b0, 1'b1, 5'd31, 5'd0, 5'd31, 1'b1, 1'b0), 64'd5, 1'b0, 64'd0);
    read_reg(31, 64'd0);

    // Signed overflow, then A-A for carry-out with zero result
    step(mk(5'b00100, 1'b0, 1'b1, 5'd31, 5'd0, 5'd4, 1'b1, 1'b0), 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
    expect_val("ovf_status", K_STATUS, 0, 64'b01010);
    expect_val("ovf_addr", K_ADDR, 0, 64'd0);
    step(mk(5'b01000, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0), 64'd1, 1'b0, 64'd0);
    expect_val("cz_status", K_STATUS, 0, 64'b10101);
    step(mk(5'b01001, 1'b1, 1'b1, 5'd4, 5'd31, 5'd0, 1'b0, 1'b1), 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd0);
    expect_val("cz_cstat", K_CSTAT, 0, 64'b0101);
    read_reg(4, 64'h7FFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom};
      x  = k1 ^ k2;
      step(mk(5'b00100, 1'b0, 1'b1, 5'd31, 5'd0, 5'd5, 1'b1, 1'b0), k1, 1'b0, 64'd0);
      expect_val("xor_addr", K_ADDR, 0, {32'b0, x[31:0]});
      expect_val("xor_status", K_STATUS, 0, {59'b0, 3'b000, x[63], x == 64'd0});
      step(mk(5'b01100, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0), k2, 1'b0, 64'd0);
      read_reg(5, k1);
    end

    c = '0; c.dsel = 2'b01; c.sb = 5'd1; c.ir_ld = 1'b1;
    step(c, 64'd0, 1'b0, 64'd0);
    expect_val("ir_fetch", K_IR, 0, 64'd8);

    pcsel_seq = '{2'b00, 2'b01, 2'b10, 2'b11};
    pc_seq    = '{32'd0, 32'd0, 32'd4, 32'd8};
    for (int i = 0; i < 4; i++) begin
      c = '0; c.pc_en = 1'b1; c.asel = 1'b1; c.pcsel = pcsel_seq[i]; c.sa = 5'd1;
      expect_val($sformatf("pc_step%0d", i), K_ADDR, 0, {32'b0, pc_seq[i]});
      step(c, 64'd24, 1'b0, 64'd0);
    end

    c = '0; c.asel = 1'b1; c.dsel = 2'b10; c.da = 5'd3; c.reg_wr = 1'b1;
    expect_val("pc_branch", K_ADDR, 0, 64'd104);
    step(c, 64'd0, 1'b0, 64'd0);
    read_reg(3, 64'd108);

    step(mk(5'b00100, 1'b0, 1'b1, 5'd31, 5'd0, 5'd6, 1'b1, 1'b0), 64'h55, 1'b0, 64'd0);
    reset = 1'b1;
    c = mk(5'b00100, 1'b0, 1'b1, 5'd31, 5'd0, 5'd6, 1'b1, 1'b1);
    c.pc_en = 1'b1; c.pcsel = 2'b01; c.ir_ld = 1'b1;
    step(c, 64'hAA, 1'b0, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    c = '0; c.asel = 1'b1;
    expect_val("mrst_pc", K_ADDR, 0, 64'd0);
    expect_val("mrst_ir", K_IR, 0, 64'd0);
    expect_val("mrst_cstat", K_CSTAT, 0, 64'd0);
    step(c, 64'd0, 1'b0, 64'd0);
    for (int n = 0; n < 8; n++) read_reg(n, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
